// File: rtl/block_ram_dual_pkg.sv
// Shared sizing helpers for the dual-port block RAM.
package block_ram_dual_pkg;

  function automatic int unsigned ram_depth(input int unsigned address_width);
    return 32'd1 << address_width;
  endfunction

endpackage

// File: rtl/block_ram_rdport.sv
// Registered read port: captures the addressed word when selected, holds otherwise.
module block_ram_rdport #(
  parameter int p_data_width = 16
) (
  input  logic                    i_w_clk,
  input  logic                    i_w_reset,
  input  logic                    i_w_cs,
  input  logic [p_data_width-1:0] i_w_word,
  output logic [p_data_width-1:0] o_r_out
);

  logic [p_data_width-1:0] r_out_q;
  logic [p_data_width-1:0] r_out_d;

  // NOTE: both branches assign r_out_d, so no latch is inferred; the hold lives in the flop.
  always_comb begin
    r_out_d = i_w_cs ? i_w_word : r_out_q;
  end

  // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) r_out_q <= '0;
    else           r_out_q <= r_out_d;
  end

  assign o_r_out = r_out_q;

endmodule

// File: rtl/block_ram_dual.sv
// Single-clock block RAM: port A read/write (read-first), optional read-only port B.
module block_ram_dual
  import block_ram_dual_pkg::*;
#(
  parameter int p_data_width    = 16,
  parameter int p_address_width = 10,
  parameter bit p_port_b_enable = 1'b1
) (
  input  logic                       i_w_clk,
  input  logic                       i_w_reset,
  input  logic [p_data_width-1:0]    i_w_in,
  input  logic [p_address_width-1:0] i_w_address_a,
  input  logic                       i_w_we,
  input  logic                       i_w_cs_a,
  output logic [p_data_width-1:0]    o_r_out_a,
  input  logic [p_address_width-1:0] i_w_address_b,
  input  logic                       i_w_cs_b,
  output logic [p_data_width-1:0]    o_r_out_b
);

  localparam int unsigned l_depth = ram_depth(p_address_width);

  // Name and range are relied on by parents for hierarchical memory-file preload.
  logic [p_data_width-1:0] l_r_data [0:l_depth-1];

  // NOTE: the array has no reset so contents survive reset and map onto block RAM.
  always_ff @(posedge i_w_clk) begin
    if (!i_w_reset && i_w_cs_a && i_w_we) l_r_data[i_w_address_a] <= i_w_in;
  end

  block_ram_rdport #(.p_data_width(p_data_width)) u_rdport_a (
    .i_w_clk   (i_w_clk),
    .i_w_reset (i_w_reset),
    .i_w_cs    (i_w_cs_a),
    .i_w_word  (l_r_data[i_w_address_a]),
    .o_r_out   (o_r_out_a)
  );

  generate
    if (p_port_b_enable) begin : g_port_b
      block_ram_rdport #(.p_data_width(p_data_width)) u_rdport_b (
        .i_w_clk   (i_w_clk),
        .i_w_reset (i_w_reset),
        .i_w_cs    (i_w_cs_b),
        .i_w_word  (l_r_data[i_w_address_b]),
        .o_r_out   (o_r_out_b)
      );
    end else begin : g_no_port_b
      assign o_r_out_b = '0;
    end
  endgenerate

endmodule

// File: tb/tb_block_ram_dual.sv
// Randomized and directed checks of block_ram_dual against an array reference model.
module tb_block_ram_dual;

  logic        clk;
  logic        rst;
  logic [15:0] w_in;
  logic [9:0]  w_addr_a;
  logic        w_we;
  logic        w_cs_a;
  logic [9:0]  w_addr_b;
  logic        w_cs_b;
  logic [15:0] out_a, out_b, nob_out_a, nob_out_b;

  logic [15:0] model [0:1023];
  logic [15:0] exp_a, exp_b;
  int checks = 0;
  int errors = 0;

  block_ram_dual u_dut (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_in(w_in),
    .i_w_address_a(w_addr_a), .i_w_we(w_we), .i_w_cs_a(w_cs_a), .o_r_out_a(out_a),
    .i_w_address_b(w_addr_b), .i_w_cs_b(w_cs_b), .o_r_out_b(out_b)
  );

  block_ram_dual #(.p_port_b_enable(1'b0)) u_dut_nob (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_in(w_in),
    .i_w_address_a(w_addr_a), .i_w_we(w_we), .i_w_cs_a(w_cs_a), .o_r_out_a(nob_out_a),
    .i_w_address_b(w_addr_b), .i_w_cs_b(w_cs_b), .o_r_out_b(nob_out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle from a falling edge, applies the memory rules at the rising edge,
  // and returns at the next falling edge where outputs are sampled.
  task automatic step(input logic cs_a, input logic we, input logic [9:0] a,
                      input logic [15:0] d, input logic cs_b, input logic [9:0] b);
    w_cs_a = cs_a; w_we = we; w_addr_a = a; w_in = d; w_cs_b = cs_b; w_addr_b = b;
    @(posedge clk);
    if (rst) begin
      exp_a = '0;
      exp_b = '0;
    end else begin
      if (cs_a) exp_a = model[a];
      if (cs_b) exp_b = model[b];
      if (cs_a && we) model[a] = d;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    w_in = '0; w_addr_a = '0; w_we = 1'b0; w_cs_a = 1'b0; w_addr_b = '0; w_cs_b = 1'b0;
    exp_a = '0; exp_b = '0;
    #1;
    checks++; if (out_a !== 16'h0000) begin errors++; $display("FAIL reset_out_a got %h exp %h", out_a, 16'h0000); end
    checks++; if (out_b !== 16'h0000) begin errors++; $display("FAIL reset_out_b got %h exp %h", out_b, 16'h0000); end
    checks++; if (nob_out_b !== 16'h0000) begin errors++; $display("FAIL reset_nob_out_b got %h exp %h", nob_out_b, 16'h0000); end
    @(negedge clk);
    step(1'b1, 1'b0, 10'd5, 16'h0, 1'b1, 10'd9);
    checks++; if (out_a !== 16'h0000) begin errors++; $display("FAIL reset_hold_a got %h exp %h", out_a, 16'h0000); end
    rst = 1'b0;
  endtask

  task automatic test_preload();
    for (int i = 0; i < 1024; i++) step(1'b1, 1'b1, i[9:0], i[15:0], 1'b0, 10'd0);
  endtask

  task automatic test_read_basic();
    step(1'b1, 1'b0, 10'd5, 16'h0, 1'b1, 10'd1023);
    checks++; if (out_a !== 16'h0005) begin errors++; $display("FAIL read_a5 got %h exp %h", out_a, 16'h0005); end
    checks++; if (out_b !== 16'h03FF) begin errors++; $display("FAIL read_b1023 got %h exp %h", out_b, 16'h03FF); end
    checks++; if (nob_out_a !== 16'h0005) begin errors++; $display("FAIL nob_read_a5 got %h exp %h", nob_out_a, 16'h0005); end
    checks++; if (nob_out_b !== 16'h0000) begin errors++; $display("FAIL nob_read_b got %h exp %h", nob_out_b, 16'h0000); end
  endtask

  task automatic test_write_read_first();
    step(1'b1, 1'b1, 10'd12, 16'hBEEF, 1'b0, 10'd0);
    checks++; if (out_a !== 16'h000C) begin errors++; $display("FAIL write_old_a got %h exp %h", out_a, 16'h000C); end
    checks++; if (out_b !== 16'h03FF) begin errors++; $display("FAIL b_hold_cs0 got %h exp %h", out_b, 16'h03FF); end
    step(1'b1, 1'b0, 10'd12, 16'h0, 1'b0, 10'd0);
    checks++; if (out_a !== 16'hBEEF) begin errors++; $display("FAIL readback_12 got %h exp %h", out_a, 16'hBEEF); end
  endtask

  task automatic test_collision();
    step(1'b1, 1'b1, 10'd7, 16'h1234, 1'b1, 10'd7);
    checks++; if (out_b !== 16'h0007) begin errors++; $display("FAIL collision_b_old got %h exp %h", out_b, 16'h0007); end
    checks++; if (out_a !== 16'h0007) begin errors++; $display("FAIL collision_a_old got %h exp %h", out_a, 16'h0007); end
    step(1'b0, 1'b0, 10'd0, 16'h0, 1'b1, 10'd7);
    checks++; if (out_b !== 16'h1234) begin errors++; $display("FAIL collision_b_new got %h exp %h", out_b, 16'h1234); end
    checks++; if (out_a !== 16'h0007) begin errors++; $display("FAIL a_hold_cs0 got %h exp %h", out_a, 16'h0007); end
  endtask

  task automatic test_cs_low();
    step(1'b1, 1'b0, 10'd12, 16'h0, 1'b0, 10'd0);
    step(1'b0, 1'b1, 10'd3, 16'hFFFF, 1'b0, 10'd0);
    checks++; if (out_a !== 16'hBEEF) begin errors++; $display("FAIL cs_low_hold got %h exp %h", out_a, 16'hBEEF); end
    step(1'b1, 1'b0, 10'd3, 16'h0, 1'b0, 10'd0);
    checks++; if (out_a !== 16'h0003) begin errors++; $display("FAIL cs_low_nowrite got %h exp %h", out_a, 16'h0003); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 10'd12, 16'h0, 1'b1, 10'd12);
    checks++; if (out_a !== 16'hBEEF) begin errors++; $display("FAIL pre_reset_a got %h exp %h", out_a, 16'hBEEF); end
    #2 rst = 1'b1;
    #1;
    exp_a = '0; exp_b = '0;
    checks++; if (out_a !== 16'h0000) begin errors++; $display("FAIL async_reset_a got %h exp %h", out_a, 16'h0000); end
    checks++; if (out_b !== 16'h0000) begin errors++; $display("FAIL async_reset_b got %h exp %h", out_b, 16'h0000); end
    step(1'b1, 1'b1, 10'd12, 16'h0000, 1'b1, 10'd12);
    checks++; if (out_a !== 16'h0000) begin errors++; $display("FAIL reset_edge_a got %h exp %h", out_a, 16'h0000); end
    rst = 1'b0;
    step(1'b1, 1'b0, 10'd12, 16'h0, 1'b1, 10'd12);
    checks++; if (out_a !== 16'hBEEF) begin errors++; $display("FAIL post_reset_a got %h exp %h", out_a, 16'hBEEF); end
    checks++; if (out_b !== 16'hBEEF) begin errors++; $display("FAIL post_reset_b got %h exp %h", out_b, 16'hBEEF); end
  endtask

  task automatic test_reset_write_drop();
    rst = 1'b1;
    step(1'b1, 1'b1, 10'd20, 16'hAAAA, 1'b0, 10'd0);
    rst = 1'b0;
    step(1'b1, 1'b0, 10'd20, 16'h0, 1'b0, 10'd0);
    checks++; if (out_a !== 16'h0014) begin errors++; $display("FAIL reset_write_drop got %h exp %h", out_a, 16'h0014); end
  endtask

  task automatic test_random();
    logic [9:0] a, b;
    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(0, 1023));
      b = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(0, 1023));
      rst = ($urandom_range(0, 49) == 0);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom),
           1'($urandom_range(0, 1)), b);
      checks++; if (out_a !== exp_a) begin errors++; $display("FAIL rand_a[%0d] got %h exp %h", n, out_a, exp_a); end
      checks++; if (out_b !== exp_b) begin errors++; $display("FAIL rand_b[%0d] got %h exp %h", n, out_b, exp_b); end
      checks++; if (nob_out_a !== exp_a) begin errors++; $display("FAIL rand_nob_a[%0d] got %h exp %h", n, nob_out_a, exp_a); end
      checks++; if (nob_out_b !== 16'h0000) begin errors++; $display("FAIL rand_nob_b[%0d] got %h exp %h", n, nob_out_b, 16'h0000); end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_preload();
    test_read_basic();
    test_write_read_first();
    test_collision();
    test_cs_low();
    test_reset_mid();
    test_reset_write_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
